// File: rtl/fuel_dispense_seq.sv
// -----------------------------------------------------------------------------
// fuel_dispense_seq
// Per-pump dispense sequencer. On start it latches the prepaid amount and the
// fuel grade, then opens the selected grade valve while the nozzle trigger is
// held. Flow-meter ticks are charged at the grade price. The pump stops as soon
// as the next tick could no longer be paid for, when the tick counter
// saturates, when the nozzle has been released too long, or when the sale is
// aborted. Spent, change and tick counts feed the display datapath.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   start      in   1      level: high = transaction open, low = close/abort
//   valve      in   1      nozzle trigger level, synchronous to clk
//   select     in   3      grade code, 1..3 valid
//   keyboard   in   AMT_W  prepaid amount in VND
//   flow_pulse in   1      one-cycle strobe per 10 mL dispensed
//   gas        out  3      one-hot grade valve enable (001/010/100)
//   busy       out  1      sale in progress (armed, fuelling or paused)
//   done       out  1      sale closed, spent/change valid
//   err        out  1      request rejected
//   spent      out  AMT_W  VND dispensed so far
//   change     out  AMT_W  prepaid minus spent while done, else 0
//   ticks      out  16     flow ticks counted
// -----------------------------------------------------------------------------
module fuel_dispense_seq #(
  parameter int AMT_W    = 24,
  parameter int PRICE1   = 230,
  parameter int PRICE2   = 250,
  parameter int PRICE3   = 210,
  parameter int PAUSE_TO = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             valve,
  input  logic [2:0]       select,
  input  logic [AMT_W-1:0] keyboard,
  input  logic             flow_pulse,
  output logic [2:0]       gas,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] spent,
  output logic [AMT_W-1:0] change,
  output logic [15:0]      ticks
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    FUEL  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int PCNT_W = (PAUSE_TO > 2) ? $clog2(PAUSE_TO) : 1;
  localparam logic [PCNT_W-1:0] PAUSE_LAST = PCNT_W'(PAUSE_TO - 1);

  localparam logic [AMT_W-1:0] PRICE_G1 = AMT_W'(PRICE1);
  localparam logic [AMT_W-1:0] PRICE_G2 = AMT_W'(PRICE2);
  localparam logic [AMT_W-1:0] PRICE_G3 = AMT_W'(PRICE3);

  localparam logic [15:0] TICKS_MAX = 16'hFFFF;

  // State and latched sale parameters
  state_t             state_q,    state_d;
  logic [AMT_W-1:0]   amt_q,      amt_d;
  logic [AMT_W-1:0]   price_q,    price_d;
  logic [2:0]         gradeOh_q,  gradeOh_d;
  logic [PCNT_W-1:0]  pauseCnt_q, pauseCnt_d;

  // Registered outputs
  logic [AMT_W-1:0]   spent_q,    spent_d;
  logic [AMT_W-1:0]   change_q,   change_d;
  logic [15:0]        ticks_q,    ticks_d;
  logic [2:0]         gas_q,      gas_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               err_q,      err_d;

  // Grade decode of the live select input; only used at the latch point
  logic [AMT_W-1:0]   selPrice;
  logic [2:0]         selOneHot;
  logic               selValid;

  // Spent/ticks including the tick arriving this cycle. Only consumed while
  // fuelling, where at least one price step of credit is always left, so
  // the addition cannot exceed the prepaid amount.
  logic [AMT_W-1:0]   pulseSpent;
  logic [15:0]        pulseTicks;
  logic [AMT_W-1:0]   pulseLeft;

  assign pulseSpent = flow_pulse ? (spent_q + price_q) : spent_q;
  assign pulseTicks = flow_pulse ? (ticks_q + 16'd1)   : ticks_q;
  assign pulseLeft  = amt_q - pulseSpent;

  always_comb begin
    selPrice  = '0;
    selOneHot = 3'b000;
    selValid  = 1'b0;
    case (select)
      3'd1: begin
        selPrice  = PRICE_G1;
        selOneHot = 3'b001;
        selValid  = 1'b1;
      end
      3'd2: begin
        selPrice  = PRICE_G2;
        selOneHot = 3'b010;
        selValid  = 1'b1;
      end
      3'd3: begin
        selPrice  = PRICE_G3;
        selOneHot = 3'b100;
        selValid  = 1'b1;
      end
      default: begin
        selPrice  = '0;
        selOneHot = 3'b000;
        selValid  = 1'b0;
      end
    endcase
  end

  // Next-state and next-output computation
  always_comb begin
    state_d    = state_q;
    amt_d      = amt_q;
    price_d    = price_q;
    gradeOh_d  = gradeOh_q;
    pauseCnt_d = pauseCnt_q;
    spent_d    = spent_q;
    change_d   = change_q;
    ticks_d    = ticks_q;

    case (state_q)
      IDLE: begin
        spent_d    = '0;
        ticks_d    = '0;
        change_d   = '0;
        pauseCnt_d = '0;
        if (start) begin
          amt_d     = keyboard;
          price_d   = selPrice;
          gradeOh_d = selOneHot;
          if (!selValid || (keyboard == '0) || (keyboard < selPrice)) begin
            state_d = ERR;
          end else begin
            state_d = ARMED;
          end
        end
      end

      ARMED: begin
        if (!start) begin
          state_d = IDLE;
        end else if (valve) begin
          state_d = FUEL;
        end
      end

      FUEL: begin
        // A tick is charged even when it coincides with a valve or start drop
        spent_d = pulseSpent;
        ticks_d = pulseTicks;
        if (!start || (pulseLeft < price_q) || (pulseTicks == TICKS_MAX)) begin
          state_d  = DONE;
          change_d = pulseLeft;
        end else if (!valve) begin
          state_d    = PAUSE;
          pauseCnt_d = '0;
        end
      end

      PAUSE: begin
        if (!start) begin
          state_d  = DONE;
          change_d = amt_q - spent_q;
        end else if (valve) begin
          state_d    = FUEL;
          pauseCnt_d = '0;
        end else if (pauseCnt_q == PAUSE_LAST) begin
          state_d  = DONE;
          change_d = amt_q - spent_q;
        end else begin
          pauseCnt_d = pauseCnt_q + 1'b1;
        end
      end

      DONE: begin
        if (!start) begin
          state_d  = IDLE;
          spent_d  = '0;
          ticks_d  = '0;
          change_d = '0;
        end
      end

      ERR: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        spent_d  = '0;
        ticks_d  = '0;
        change_d = '0;
      end
    endcase

    // Flags are derived from the state being entered so that each output
    // register agrees with the state register after every edge.
    gas_d  = (state_d == FUEL) ? gradeOh_d : 3'b000;
    busy_d = (state_d == ARMED) || (state_d == FUEL) || (state_d == PAUSE);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      amt_q      <= '0;
      price_q    <= '0;
      gradeOh_q  <= 3'b000;
      pauseCnt_q <= '0;
      spent_q    <= '0;
      change_q   <= '0;
      ticks_q    <= '0;
      gas_q      <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      amt_q      <= amt_d;
      price_q    <= price_d;
      gradeOh_q  <= gradeOh_d;
      pauseCnt_q <= pauseCnt_d;
      spent_q    <= spent_d;
      change_q   <= change_d;
      ticks_q    <= ticks_d;
      gas_q      <= gas_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign gas    = gas_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign spent  = spent_q;
  assign change = change_q;
  assign ticks  = ticks_q;

endmodule

// File: tb/tb_fuel_dispense_seq.sv
// -----------------------------------------------------------------------------
// tb_fuel_dispense_seq
// Directed bench for fuel_dispense_seq. A sale-level reference model tracks
// the transaction phase, money and tick totals from the input stream and is
// compared against every DUT output after each clock edge. Hand-computed
// literal values at key points of each scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_fuel_dispense_seq;

  localparam int AMT_W    = 24;
  localparam int PAUSE_TO = 500;

  logic             clk;
  logic             reset;
  logic             start;
  logic             valve;
  logic [2:0]       select;
  logic [AMT_W-1:0] keyboard;
  logic             flow_pulse;
  logic [2:0]       gas;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] spent;
  logic [AMT_W-1:0] change;
  logic [15:0]      ticks;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  fuel_dispense_seq #(
    .AMT_W   (AMT_W),
    .PRICE1  (230),
    .PRICE2  (250),
    .PRICE3  (210),
    .PAUSE_TO(PAUSE_TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .valve     (valve),
    .select    (select),
    .keyboard  (keyboard),
    .flow_pulse(flow_pulse),
    .gas       (gas),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .spent     (spent),
    .change    (change),
    .ticks     (ticks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Sale phases of the reference model
  localparam int CLOSED   = 0;
  localparam int READY    = 1;
  localparam int POURING  = 2;
  localparam int HELD     = 3;
  localparam int SETTLED  = 4;
  localparam int REJECTED = 5;

  int     mPhase;
  int     mGrade;
  int     mIdle;
  longint mAmt;
  longint mPrice;
  longint mSpent;
  longint mTicks;

  function automatic longint priceOf(input logic [2:0] s);
    case (s)
      3'd1:    return 230;
      3'd2:    return 250;
      3'd3:    return 210;
      default: return 0;
    endcase
  endfunction

  task automatic modelReset();
    mPhase = CLOSED;
    mGrade = 0;
    mIdle  = 0;
    mAmt   = 0;
    mPrice = 0;
    mSpent = 0;
    mTicks = 0;
  endtask

  task automatic modelStep();
    case (mPhase)
      CLOSED: begin
        if (start) begin
          mGrade = int'(select);
          mPrice = priceOf(select);
          mAmt   = longint'(keyboard);
          mSpent = 0;
          mTicks = 0;
          if (mPrice == 0 || mAmt == 0 || mAmt < mPrice) mPhase = REJECTED;
          else mPhase = READY;
        end
      end
      READY: begin
        if (!start) mPhase = CLOSED;
        else if (valve) mPhase = POURING;
      end
      POURING: begin
        if (flow_pulse) begin
          mSpent = mSpent + mPrice;
          mTicks = mTicks + 1;
        end
        if (!start || (mAmt - mSpent) < mPrice || mTicks == 65535) begin
          mPhase = SETTLED;
        end else if (!valve) begin
          mPhase = HELD;
          mIdle  = 0;
        end
      end
      HELD: begin
        if (!start) mPhase = SETTLED;
        else if (valve) mPhase = POURING;
        else begin
          mIdle = mIdle + 1;
          if (mIdle == PAUSE_TO) mPhase = SETTLED;
        end
      end
      SETTLED: begin
        if (!start) begin
          mPhase = CLOSED;
          mSpent = 0;
          mTicks = 0;
        end
      end
      REJECTED: begin
        if (!start) mPhase = CLOSED;
      end
      default: mPhase = CLOSED;
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) modelReset();
    else modelStep();
  end

  // Every-cycle comparison against the model, shortly after each edge
  always @(posedge clk) begin
    #1;
    if (cmpEn) begin
      checkOutput("model_gas", {61'd0, gas},
                  (mPhase == POURING) ? 64'(1 << (mGrade - 1)) : 64'd0);
      checkOutput("model_busy", {63'd0, busy},
                  64'(mPhase == READY || mPhase == POURING || mPhase == HELD));
      checkOutput("model_done", {63'd0, done}, 64'(mPhase == SETTLED));
      checkOutput("model_err", {63'd0, err}, 64'(mPhase == REJECTED));
      checkOutput("model_spent", 64'(spent), 64'(mSpent));
      checkOutput("model_change", 64'(change),
                  (mPhase == SETTLED) ? 64'(mAmt - mSpent) : 64'd0);
      checkOutput("model_ticks", 64'(ticks), 64'(mTicks));
    end
  end

  // Drive one cycle of inputs and return just after the edge that used them
  task automatic applyStimulus(input logic s, input logic v, input logic [2:0] sel,
                               input logic [AMT_W-1:0] kb, input logic p);
    @(negedge clk);
    start      = s;
    valve      = v;
    select     = sel;
    keyboard   = kb;
    flow_pulse = p;
    @(posedge clk);
    #2;
  endtask

  task automatic holdCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput(name, {63'd0, done}, 64'd1);
  endtask

  task automatic closeSale();
    applyStimulus(1'b0, 1'b0, 3'd0, '0, 1'b0);
    checkOutput("close_busy", {63'd0, busy}, 64'd0);
    checkOutput("close_done", {63'd0, done}, 64'd0);
    checkOutput("close_spent", 64'(spent), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    valve      = 1'b0;
    select     = 3'd0;
    keyboard   = '0;
    flow_pulse = 1'b0;
    #1 reset   = 1'b0;
    #2;
    checkOutput("rst_gas", {61'd0, gas}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_err", {63'd0, err}, 64'd0);
    checkOutput("rst_spent", 64'(spent), 64'd0);
    checkOutput("rst_change", 64'(change), 64'd0);
    checkOutput("rst_ticks", 64'(ticks), 64'd0);
    cmpEn = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // Scenario 1: 50000 VND of grade 1, continuous ticks
    applyStimulus(1'b1, 1'b0, 3'd1, 24'd50000, 1'b0);
    checkOutput("s1_armed_busy", {63'd0, busy}, 64'd1);
    applyStimulus(1'b1, 1'b1, 3'd1, 24'd50000, 1'b1);
    checkOutput("s1_gas_on", {61'd0, gas}, 64'b001);
    checkOutput("s1_no_tick_armed", 64'(ticks), 64'd0);
    waitDone("s1_done", 300);
    checkOutput("s1_ticks", 64'(ticks), 64'd217);
    checkOutput("s1_spent", 64'(spent), 64'd49910);
    checkOutput("s1_change", 64'(change), 64'd90);
    checkOutput("s1_gas_off", {61'd0, gas}, 64'd0);
    holdCycles(3);
    checkOutput("s1_ticks_hold", 64'(ticks), 64'd217);
    closeSale();

    // Scenario 2: exact multiple of the grade 2 price
    applyStimulus(1'b1, 1'b0, 3'd2, 24'd100000, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd2, 24'd100000, 1'b1);
    checkOutput("s2_gas_on", {61'd0, gas}, 64'b010);
    waitDone("s2_done", 500);
    checkOutput("s2_ticks", 64'(ticks), 64'd400);
    checkOutput("s2_spent", 64'(spent), 64'd100000);
    checkOutput("s2_change", 64'(change), 64'd0);
    closeSale();

    // Scenario 3: rejected requests and the exact-price boundary
    applyStimulus(1'b1, 1'b0, 3'd0, 24'd5000, 1'b0);
    checkOutput("s3_err_sel0", {63'd0, err}, 64'd1);
    applyStimulus(1'b1, 1'b1, 3'd0, 24'd5000, 1'b1);
    checkOutput("s3_err_gas", {61'd0, gas}, 64'd0);
    checkOutput("s3_err_ticks", 64'(ticks), 64'd0);
    closeSale();
    checkOutput("s3_err_clear", {63'd0, err}, 64'd0);
    applyStimulus(1'b1, 1'b0, 3'd2, 24'd200, 1'b0);
    checkOutput("s3_err_short", {63'd0, err}, 64'd1);
    closeSale();
    applyStimulus(1'b1, 1'b0, 3'd1, 24'd0, 1'b0);
    checkOutput("s3_err_zero", {63'd0, err}, 64'd1);
    closeSale();
    applyStimulus(1'b1, 1'b0, 3'd7, 24'd9000, 1'b0);
    checkOutput("s3_err_sel7", {63'd0, err}, 64'd1);
    closeSale();
    applyStimulus(1'b1, 1'b0, 3'd3, 24'd210, 1'b0);
    checkOutput("s3_exact_err", {63'd0, err}, 64'd0);
    checkOutput("s3_exact_busy", {63'd0, busy}, 64'd1);
    applyStimulus(1'b1, 1'b1, 3'd3, 24'd210, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'd3, 24'd210, 1'b1);
    checkOutput("s3_exact_done", {63'd0, done}, 64'd1);
    checkOutput("s3_exact_ticks", 64'(ticks), 64'd1);
    checkOutput("s3_exact_change", 64'(change), 64'd0);
    closeSale();

    // Scenario 4a: grade 3, five ticks, then pause timeout
    applyStimulus(1'b1, 1'b0, 3'd3, 24'd10000, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd3, 24'd10000, 1'b0);
    checkOutput("s4_gas_on", {61'd0, gas}, 64'b100);
    applyStimulus(1'b1, 1'b1, 3'd3, 24'd10000, 1'b1);
    holdCycles(4);
    checkOutput("s4_ticks5", 64'(ticks), 64'd5);
    applyStimulus(1'b1, 1'b0, 3'd3, 24'd10000, 1'b0);
    checkOutput("s4_pause_gas", {61'd0, gas}, 64'd0);
    checkOutput("s4_pause_busy", {63'd0, busy}, 64'd1);
    applyStimulus(1'b1, 1'b0, 3'd1, 24'd99, 1'b0);
    holdCycles(PAUSE_TO - 2);
    checkOutput("s4_not_yet_done", {63'd0, done}, 64'd0);
    holdCycles(1);
    checkOutput("s4_timeout_done", {63'd0, done}, 64'd1);
    checkOutput("s4_spent", 64'(spent), 64'd1050);
    checkOutput("s4_change", 64'(change), 64'd8950);
    checkOutput("s4_ticks", 64'(ticks), 64'd5);
    closeSale();

    // Scenario 4b: pause then resume; ticks during the pause are ignored
    applyStimulus(1'b1, 1'b0, 3'd3, 24'd10000, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd3, 24'd10000, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd3, 24'd10000, 1'b1);
    holdCycles(4);
    applyStimulus(1'b1, 1'b0, 3'd3, 24'd10000, 1'b1);
    checkOutput("s4b_drop_tick", 64'(ticks), 64'd6);
    holdCycles(99);
    checkOutput("s4b_pause_ticks", 64'(ticks), 64'd6);
    applyStimulus(1'b1, 1'b1, 3'd3, 24'd10000, 1'b0);
    checkOutput("s4b_resume_gas", {61'd0, gas}, 64'b100);
    checkOutput("s4b_resume_done", {63'd0, done}, 64'd0);
    applyStimulus(1'b1, 1'b1, 3'd3, 24'd10000, 1'b1);
    holdCycles(2);
    checkOutput("s4b_ticks9", 64'(ticks), 64'd9);
    applyStimulus(1'b0, 1'b1, 3'd3, 24'd10000, 1'b0);
    checkOutput("s4b_abort_done", {63'd0, done}, 64'd1);
    checkOutput("s4b_spent", 64'(spent), 64'd1890);
    checkOutput("s4b_change", 64'(change), 64'd8110);
    closeSale();

    // Scenario 5: cancel while armed, abort with a coincident tick
    applyStimulus(1'b1, 1'b0, 3'd1, 24'd5000, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'd1, 24'd5000, 1'b1);
    checkOutput("s5_cancel_busy", {63'd0, busy}, 64'd0);
    checkOutput("s5_cancel_done", {63'd0, done}, 64'd0);
    checkOutput("s5_cancel_spent", 64'(spent), 64'd0);
    applyStimulus(1'b1, 1'b0, 3'd1, 24'd5000, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd1, 24'd5000, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd1, 24'd5000, 1'b1);
    holdCycles(2);
    applyStimulus(1'b0, 1'b1, 3'd1, 24'd5000, 1'b1);
    checkOutput("s5_abort_done", {63'd0, done}, 64'd1);
    checkOutput("s5_abort_ticks", 64'(ticks), 64'd4);
    checkOutput("s5_abort_spent", 64'(spent), 64'd920);
    checkOutput("s5_abort_change", 64'(change), 64'd4080);
    applyStimulus(1'b0, 1'b0, 3'd0, '0, 1'b0);

    // Scenario 6: asynchronous reset in the middle of fuelling
    applyStimulus(1'b1, 1'b0, 3'd1, 24'd5000, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd1, 24'd5000, 1'b0);
    checkOutput("s6_gas_on", {61'd0, gas}, 64'b001);
    applyStimulus(1'b1, 1'b1, 3'd1, 24'd5000, 1'b1);
    holdCycles(1);
    checkOutput("s6_ticks2", 64'(ticks), 64'd2);
    #1 reset = 1'b0;
    #1;
    checkOutput("s6_async_gas", {61'd0, gas}, 64'd0);
    checkOutput("s6_async_busy", {63'd0, busy}, 64'd0);
    checkOutput("s6_async_ticks", 64'(ticks), 64'd0);
    checkOutput("s6_async_spent", 64'(spent), 64'd0);
    holdCycles(2);
    checkOutput("s6_held_ticks", 64'(ticks), 64'd0);
    start      = 1'b0;
    valve      = 1'b0;
    flow_pulse = 1'b0;
    reset      = 1'b1;
    holdCycles(2);
    checkOutput("s6_release_ticks", 64'(ticks), 64'd0);
    checkOutput("s6_release_busy", {63'd0, busy}, 64'd0);

    cmpEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
